// File: rtl/feed_interval_scheduler.sv
// feed_interval_scheduler: counts 1 Hz ticks down from a programmable interval and raises dispense requests
module feed_interval_scheduler #(
    parameter int                    INTERVAL_W       = 17,
    parameter logic [INTERVAL_W-1:0] DEFAULT_INTERVAL = 17'd28800,
    parameter logic [7:0]            ACK_TIMEOUT      = 8'd30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  load,
    input  logic [INTERVAL_W-1:0] interval_in,
    input  logic                  feed_now,
    input  logic                  clear_fault,
    input  logic                  dispense_ack,
    output logic                  dispense_req,
    output logic [INTERVAL_W-1:0] remaining,
    output logic [15:0]           feed_count,
    output logic                  overrun,
    output logic                  fault
);
    typedef enum logic [1:0] {IDLE, COUNT, REQ, FAULT} state_t;
    localparam logic [INTERVAL_W-1:0] ONE = INTERVAL_W'(1);
    state_t                state;
    logic [INTERVAL_W-1:0] interval_reg;
    logic [7:0]            tcnt;
    logic [INTERVAL_W-1:0] new_int;
    logic [INTERVAL_W-1:0] reload;
    logic                  last;
    assign new_int = (interval_in == '0) ? ONE : interval_in;
    assign reload  = load ? new_int : interval_reg;
    assign last    = remaining == ONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            interval_reg <= DEFAULT_INTERVAL;
            remaining    <= DEFAULT_INTERVAL;
            dispense_req <= 1'b0;
            feed_count   <= '0;
            overrun      <= 1'b0;
            fault        <= 1'b0;
            tcnt         <= '0;
        end else begin
            if (load) interval_reg <= new_int;
            unique case (state)
                IDLE: begin
                    if (feed_now) begin
                        state        <= REQ;
                        dispense_req <= 1'b1;
                        tcnt         <= '0;
                        remaining    <= reload;
                    end else begin
                        if (load) remaining <= new_int;
                        if (enable) state <= COUNT;
                    end
                end
                COUNT: begin
                    // a load suppresses expiry; manual and timed requests merge into one
                    if (feed_now || (enable && tick && last && !load)) begin
                        state        <= REQ;
                        dispense_req <= 1'b1;
                        tcnt         <= '0;
                        remaining    <= reload;
                    end else begin
                        if (load) remaining <= new_int;
                        else if (enable && tick) remaining <= remaining - ONE;
                        if (!enable) state <= IDLE;
                    end
                end
                REQ: begin
                    if (tick) begin
                        remaining <= last ? interval_reg : remaining - ONE;
                        if (last) overrun <= 1'b1;
                    end
                    if (dispense_ack) begin
                        dispense_req <= 1'b0;
                        feed_count   <= feed_count + 16'd1;
                        state        <= enable ? COUNT : IDLE;
                    end else if (tick) begin
                        if (tcnt + 8'd1 == ACK_TIMEOUT) begin
                            state        <= FAULT;
                            dispense_req <= 1'b0;
                            fault        <= 1'b1;
                        end
                        tcnt <= tcnt + 8'd1;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_feed_interval_scheduler.sv
// tb_feed_interval_scheduler: directed vectors for the feed scheduler (two timeout settings)
module tb_feed_interval_scheduler;
    logic clk = 0, reset = 1, tick = 0, enable = 0, load = 0, feed_now = 0, clear_fault = 0, dispense_ack = 0;
    logic [16:0] interval_in = '0;
    logic req_a, ovr_a, flt_a, req_b, ovr_b, flt_b;
    logic [16:0] rem_a, rem_b;
    logic [15:0] cnt_a, cnt_b;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    feed_interval_scheduler #(.INTERVAL_W(17), .DEFAULT_INTERVAL(17'd5), .ACK_TIMEOUT(8'd3)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .load(load), .interval_in(interval_in),
        .feed_now(feed_now), .clear_fault(clear_fault), .dispense_ack(dispense_ack),
        .dispense_req(req_a), .remaining(rem_a), .feed_count(cnt_a), .overrun(ovr_a), .fault(flt_a));

    feed_interval_scheduler #(.INTERVAL_W(17), .DEFAULT_INTERVAL(17'd5), .ACK_TIMEOUT(8'd8)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .load(load), .interval_in(interval_in),
        .feed_now(feed_now), .clear_fault(clear_fault), .dispense_ack(dispense_ack),
        .dispense_req(req_b), .remaining(rem_b), .feed_count(cnt_b), .overrun(ovr_b), .fault(flt_b));

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1; step(); tick = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_rem", rem_a, 5);
        chk("rst_req", req_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_flt", flt_a, 0);
        chk("rst_ovr", ovr_a, 0);

        // T1: countdown and expiry
        enable = 1; step();
        for (int i = 4; i >= 1; i--) begin
            pulse_tick(1);
            chk("t1_rem", rem_a, i);
            chk("t1_req_low", req_a, 0);
        end
        pulse_tick(1);
        chk("t1_req", req_a, 1);
        chk("t1_reload", rem_a, 5);

        // T2: ack, then ack outside REQ ignored
        dispense_ack = 1; step(); dispense_ack = 0;
        chk("t2_req", req_a, 0);
        chk("t2_cnt", cnt_a, 1);
        pulse_tick(1);
        chk("t2_counting", rem_a, 4);
        enable = 0; step();
        dispense_ack = 1; step(); dispense_ack = 0;
        chk("t2_idle_ack_cnt", cnt_a, 1);
        chk("t2_idle_ack_req", req_a, 0);

        // T3: ack timeout to FAULT
        feed_now = 1; step(); feed_now = 0;
        chk("t3_req", req_a, 1);
        chk("t3_rem", rem_a, 5);
        pulse_tick(2);
        chk("t3_still_req", req_a, 1);
        chk("t3_no_fault", flt_a, 0);
        pulse_tick(1);
        chk("t3_req_drop", req_a, 0);
        chk("t3_fault", flt_a, 1);
        feed_now = 1; step(); feed_now = 0;
        chk("t3_feed_ign", req_a, 0);
        pulse_tick(1);
        chk("t3_frozen", rem_a, 2);
        clear_fault = 1; step(); clear_fault = 0;
        chk("t3_clear", flt_a, 0);
        chk("t3_ovr", ovr_a, 0);
        dispense_ack = 1; step(); dispense_ack = 0;
        chk("t3_ack_idle", cnt_a, 1);

        // T4: load of zero coerced to 1, load beats tick
        enable = 1; step();
        load = 1; interval_in = 0; step(); load = 0;
        chk("t4_rem1", rem_a, 1);
        pulse_tick(1);
        chk("t4_req", req_a, 1);
        chk("t4_reload1", rem_a, 1);
        dispense_ack = 1; step(); dispense_ack = 0;
        chk("t4_cnt", cnt_a, 2);
        load = 1; interval_in = 4; tick = 1; step(); load = 0; tick = 0;
        chk("t4_load_wins", rem_a, 4);
        chk("t4_no_req", req_a, 0);

        // T5: disabled freezes countdown, manual feed still works
        do_reset();
        enable = 1; step();
        pulse_tick(2);
        chk("t5_rem3", rem_a, 3);
        enable = 0; step();
        pulse_tick(4);
        chk("t5_frozen", rem_a, 3);
        chk("t5_req_low", req_a, 0);
        feed_now = 1; step(); feed_now = 0;
        chk("t5_req", req_a, 1);
        chk("t5_rem5", rem_a, 5);

        // T6: long REQ on the 8-tick timeout instance overruns once
        do_reset();
        enable = 1; step();
        feed_now = 1; step(); feed_now = 0;
        chk("t6_req", req_b, 1);
        pulse_tick(4);
        chk("t6_rem1", rem_b, 1);
        chk("t6_no_ovr", ovr_b, 0);
        pulse_tick(1);
        chk("t6_ovr", ovr_b, 1);
        chk("t6_reload", rem_b, 5);
        chk("t6_single_req", req_b, 1);
        chk("t6_no_fault", flt_b, 0);
        chk("t6_cnt0", cnt_b, 0);
        do_reset();
        chk("t6_rst_req", req_b, 0);
        chk("t6_rst_ovr", ovr_b, 0);
        chk("t6_rst_rem", rem_b, 5);
        chk("t6_rst_flt", flt_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
